// File: rtl/dmem_pkg.sv
// Shared encodings, default base address and FSM state type for the data-memory responder.
package dmem_pkg;

  localparam logic [1:0] DW_WORD = 2'b00;
  localparam logic [1:0] DW_HALF = 2'b01;
  localparam logic [1:0] DW_BYTE = 2'b10;
  localparam logic [1:0] DW_RSVD = 2'b11;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  // Byte-write-enable for a store of width dw at byte offset off within the word.
  function automatic logic [3:0] lane_be(input logic [1:0] dw, input logic [1:0] off);
    logic [3:0] be;
    case (dw)
      DW_WORD: be = 4'b1111;
      DW_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      DW_BYTE: be = 4'b0001 << off;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 storage: per-byte synchronous write, asynchronous read. No reset on contents.
module dmem_array #(
  parameter int unsigned DEPTH = 2048,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];

  // Byte-lane write; unselected lanes keep their contents.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) begin
        mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: post-reset clear sweep, alignment/range checking,
// byte/half/word lane steering and access/fault statistics.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH     = 2048,
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dmem_ena,
  input  logic             dmem_wena,
  input  logic [31:0]      dmem_addr,
  input  logic [31:0]      dmem_in,
  input  logic [1:0]       d_ram_instr,
  output logic [31:0]      dmem_out,
  output logic             busy,
  output logic             fault,
  output logic [31:0]      fault_addr,
  output logic [CNT_W-1:0] load_cnt,
  output logic [CNT_W-1:0] store_cnt,
  output logic [CNT_W-1:0] fault_cnt
);

  localparam int unsigned    AW       = $clog2(DEPTH);
  localparam logic [31:0]    SPAN     = 32'(4 * DEPTH);
  localparam logic [AW-1:0]  LAST_IDX = AW'(DEPTH - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            fault_q, fault_d;
  logic [31:0]     fault_addr_q, fault_addr_d;
  logic [CNT_W-1:0] load_cnt_q, load_cnt_d;
  logic [CNT_W-1:0] store_cnt_q, store_cnt_d;
  logic [CNT_W-1:0] fault_cnt_q, fault_cnt_d;

  logic [31:0]     offset_s;
  logic            in_range_s;
  logic            misalign_s;
  logic            req_s;
  logic            accept_s;
  logic            reject_s;
  logic [AW-1:0]   idx_s;
  logic [3:0]      we_s;
  logic [AW-1:0]   waddr_s;
  logic [31:0]     wdata_s;
  logic [31:0]     rdata_s;
  logic [31:0]     steer_s;

  // A wrapped subtraction lands far above SPAN, so one compare covers both ends.
  assign offset_s   = dmem_addr - BASE_ADDR;
  assign in_range_s = (offset_s < SPAN);
  assign idx_s      = offset_s[AW+1:2];
  assign req_s      = (state_q == READY) && dmem_ena;
  assign accept_s   = req_s && in_range_s && !misalign_s;
  assign reject_s   = req_s && !accept_s;

  // Width/alignment legality of the current request.
  always_comb begin
    misalign_s = 1'b0;
    case (d_ram_instr)
      DW_WORD: misalign_s = (dmem_addr[1:0] != 2'b00);
      DW_HALF: misalign_s = dmem_addr[0];
      DW_BYTE: misalign_s = 1'b0;
      default: misalign_s = 1'b1;
    endcase
  end

  // Replicate store data across lanes so the byte enables pick the right copy.
  always_comb begin
    steer_s = dmem_in;
    case (d_ram_instr)
      DW_WORD: steer_s = dmem_in;
      DW_HALF: steer_s = {2{dmem_in[15:0]}};
      DW_BYTE: steer_s = {4{dmem_in[7:0]}};
      default: steer_s = dmem_in;
    endcase
  end

  // Write port: sweep owns it during CLEAR, accepted stores in READY.
  always_comb begin
    we_s    = 4'b0000;
    waddr_s = idx_s;
    wdata_s = steer_s;
    if (state_q == CLEAR) begin
      we_s    = 4'b1111;
      waddr_s = ptr_q;
      wdata_s = 32'h0000_0000;
    end else if (accept_s && dmem_wena) begin
      we_s = lane_be(d_ram_instr, dmem_addr[1:0]);
    end else begin
      we_s = 4'b0000;
    end
  end

  dmem_array #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_array (
    .clk  (clk),
    .we   (we_s),
    .waddr(waddr_s),
    .wdata(wdata_s),
    .raddr(idx_s),
    .rdata(rdata_s)
  );

  // Load data: selected lane(s) shifted down and zero-extended; 0 unless accepted.
  always_comb begin
    dmem_out = 32'h0000_0000;
    if (accept_s) begin
      case (d_ram_instr)
        DW_WORD: dmem_out = rdata_s;
        DW_HALF: dmem_out = {16'h0000, dmem_addr[1] ? rdata_s[31:16] : rdata_s[15:0]};
        DW_BYTE: dmem_out = {24'h00_0000, 8'(rdata_s >> {dmem_addr[1:0], 3'b000})};
        default: dmem_out = 32'h0000_0000;
      endcase
    end else begin
      dmem_out = 32'h0000_0000;
    end
  end

  // FSM next state and sweep pointer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      CLEAR: begin
        ptr_d = ptr_q + AW'(1);
        if (ptr_q == LAST_IDX) begin
          state_d = READY;
        end else begin
          state_d = CLEAR;
        end
      end
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  // Fault pulse, fault address and statistics next state.
  always_comb begin
    fault_d      = reject_s;
    fault_addr_d = fault_addr_q;
    load_cnt_d   = load_cnt_q;
    store_cnt_d  = store_cnt_q;
    fault_cnt_d  = fault_cnt_q;
    if (reject_s) begin
      fault_addr_d = dmem_addr;
      fault_cnt_d  = fault_cnt_q + CNT_W'(1);
    end else if (accept_s && dmem_wena) begin
      store_cnt_d = store_cnt_q + CNT_W'(1);
    end else if (accept_s) begin
      load_cnt_d = load_cnt_q + CNT_W'(1);
    end else begin
      fault_addr_d = fault_addr_q;
    end
  end

  // State, pointer and statistics registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= CLEAR;
      ptr_q        <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= 32'h0000_0000;
      load_cnt_q   <= '0;
      store_cnt_q  <= '0;
      fault_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
      load_cnt_q   <= load_cnt_d;
      store_cnt_q  <= store_cnt_d;
      fault_cnt_q  <= fault_cnt_d;
    end
  end

  assign busy       = (state_q == CLEAR);
  assign fault      = fault_q;
  assign fault_addr = fault_addr_q;
  assign load_cnt   = load_cnt_q;
  assign store_cnt  = store_cnt_q;
  assign fault_cnt  = fault_cnt_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder with DEPTH=16: stimulus queues expected
// load data and fault addresses; a negedge monitor pops and compares them.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        dmem_ena, dmem_wena;
  logic [31:0] dmem_addr, dmem_in;
  logic [1:0]  d_ram_instr;
  logic [31:0] dmem_out, fault_addr;
  logic        busy, fault;
  logic [15:0] load_cnt, store_cnt, fault_cnt;

  typedef struct {
    logic [31:0] addr;
    int          cyc;
  } fexp_t;

  logic [31:0] lq[$];
  fexp_t       fq[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          nload = 0, nstore = 0, nfault = 0;

  dmem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .dmem_ena(dmem_ena), .dmem_wena(dmem_wena),
    .dmem_addr(dmem_addr), .dmem_in(dmem_in), .d_ram_instr(d_ram_instr),
    .dmem_out(dmem_out), .busy(busy), .fault(fault), .fault_addr(fault_addr),
    .load_cnt(load_cnt), .store_cnt(store_cnt), .fault_cnt(fault_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every load cycle and every fault pulse must match a queued expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && dmem_ena && !dmem_wena) begin
      if (lq.size() == 0) chk("load_unexpected", dmem_out, 32'hxxxx_xxxx);
      else chk("load_data", dmem_out, lq.pop_front());
    end
    if (fault === 1'b1) begin
      if (fq.size() == 0) begin
        chk("fault_unexpected", fault_addr, 32'hxxxx_xxxx);
      end else begin
        fexp_t e;
        e = fq.pop_front();
        chk("fault_addr", fault_addr, e.addr);
        chk("fault_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic acc(input logic we, input logic [1:0] dw, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] exp_out, input logic is_bad);
    fexp_t e;
    dmem_ena = 1'b1; dmem_wena = we; d_ram_instr = dw; dmem_addr = a; dmem_in = d;
    if (!we) lq.push_back(exp_out);
    if (is_bad) begin
      e.addr = a; e.cyc = cyc + 1;
      fq.push_back(e);
      nfault++;
    end else if (we) nstore++;
    else nload++;
    @(posedge clk); #1;
    dmem_ena = 1'b0;
  endtask

  task automatic count_busy(input string nm);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (busy && n < 64);
    chk(nm, 32'(n), 32'(DEPTH));
  endtask

  task automatic chk_cnts(input string nm);
    chk({nm, "_load_cnt"},  32'(load_cnt),  32'(nload));
    chk({nm, "_store_cnt"}, 32'(store_cnt), 32'(nstore));
    chk({nm, "_fault_cnt"}, 32'(fault_cnt), 32'(nfault));
  endtask

  initial begin
    reset = 1'b0; dmem_ena = 1'b0; dmem_wena = 1'b0;
    dmem_addr = 32'h0; dmem_in = 32'h0; d_ram_instr = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_fault_addr", fault_addr, 32'h0);
    chk("rst_dmem_out", dmem_out, 32'h0);
    chk_cnts("rst");

    // Store held across the whole sweep must be dropped.
    dmem_ena = 1'b1; dmem_wena = 1'b1; d_ram_instr = 2'b00;
    dmem_addr = 32'h1001_0008; dmem_in = 32'hFFFF_FFFF;
    reset = 1'b1;
    count_busy("sweep_len");
    dmem_ena = 1'b0;
    chk_cnts("clear_drop");

    acc(1'b0, 2'b00, 32'h1001_0008, 32'h0, 32'h0000_0000, 1'b0);
    acc(1'b0, 2'b00, 32'h1001_003C, 32'h0, 32'h0000_0000, 1'b0);

    acc(1'b1, 2'b00, 32'h1001_0004, 32'hDEAD_BEEF, 32'h0, 1'b0);
    acc(1'b1, 2'b10, 32'h1001_0006, 32'hFFFF_FF5A, 32'h0, 1'b0);
    acc(1'b0, 2'b00, 32'h1001_0004, 32'h0, 32'hDE5A_BEEF, 1'b0);
    chk_cnts("after_store");

    acc(1'b0, 2'b10, 32'h1001_0007, 32'h0, 32'h0000_00DE, 1'b0);
    acc(1'b0, 2'b01, 32'h1001_0004, 32'h0, 32'h0000_BEEF, 1'b0);
    acc(1'b0, 2'b01, 32'h1001_0006, 32'h0, 32'h0000_DE5A, 1'b0);
    acc(1'b0, 2'b10, 32'h1001_0005, 32'h0, 32'h0000_00BE, 1'b0);

    acc(1'b1, 2'b00, 32'h1001_0000, 32'h1122_3344, 32'h0, 1'b0);
    acc(1'b1, 2'b01, 32'h1001_0003, 32'h0000_9999, 32'h0, 1'b1);
    acc(1'b0, 2'b00, 32'h1001_0000, 32'h0, 32'h1122_3344, 1'b0);
    chk_cnts("misalign_half");

    acc(1'b0, 2'b00, 32'h0FFF_FFFC, 32'h0, 32'h0, 1'b1);
    acc(1'b0, 2'b00, 32'h1001_0040, 32'h0, 32'h0, 1'b1);
    acc(1'b0, 2'b00, 32'h1001_0002, 32'h0, 32'h0, 1'b1);
    acc(1'b0, 2'b11, 32'h1001_0000, 32'h0, 32'h0, 1'b1);
    acc(1'b1, 2'b10, 32'h1001_0040, 32'h0000_0077, 32'h0, 1'b1);
    acc(1'b0, 2'b10, 32'h1001_003F, 32'h0, 32'h0000_0000, 1'b0);

    acc(1'b1, 2'b01, 32'h1001_0006, 32'h0000_CAFE, 32'h0, 1'b0);
    acc(1'b0, 2'b00, 32'h1001_0004, 32'h0, 32'hCAFE_BEEF, 1'b0);
    acc(1'b1, 2'b10, 32'h1001_0004, 32'h0000_0001, 32'h0, 1'b0);
    acc(1'b0, 2'b00, 32'h1001_0004, 32'h0, 32'hCAFE_BE01, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_cnts("final");
    chk("fault_addr_last", fault_addr, 32'h1001_0040);
    chk("fault_idle", 32'(fault), 32'd0);

    // Reset from READY, then again mid-sweep at pointer 7.
    reset = 1'b0;
    #1;
    chk("rst2_busy", 32'(busy), 32'd1);
    chk("rst2_fault_addr", fault_addr, 32'h0);
    chk("rst2_load_cnt", 32'(load_cnt), 32'd0);
    nload = 0; nstore = 0; nfault = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_busy", 32'(busy), 32'd1);
    chk_cnts("mid");
    @(posedge clk); #1;
    reset = 1'b1;
    count_busy("sweep_len2");
    acc(1'b0, 2'b00, 32'h1001_0000, 32'h0, 32'h0000_0000, 1'b0);
    acc(1'b0, 2'b00, 32'h1001_0004, 32'h0, 32'h0000_0000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_cnts("post_resweep");
    chk("lq_drained", 32'(lq.size()), 32'd0);
    chk("fq_drained", 32'(fq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
